// File: rtl/seg_pkg.sv
// Shared constants and types for the eight-digit seven-segment scan controller.
// Segment patterns are active-low {g,f,e,d,c,b,a}; anode selects are active-low.
package seg_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h10;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // BLANK is the dead-time at the head of every digit slot.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

endpackage

// File: rtl/hex_to_7seg.sv
// Hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input nibble.
module hex_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with per-slot blanking and frame-synchronous updates.
// Latency: AN/hexdisp/frame_done lag the internal slot position by one clock; loads take effect at the next frame boundary.
// Backpressure: none; load always accepted, a newer load overwrites an unapplied one.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 64
)(
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic [31:0] digits_in,
    input  logic [7:0]  digit_en,
    input  logic        load,
    output logic [7:0]  AN,
    output logic [6:0]  hexdisp,
    output logic        frame_done,
    output logic        load_pending
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    state_t        state;

    logic [31:0]   stg_dig;
    logic [7:0]    stg_en;
    logic [31:0]   sh_dig;
    logic [7:0]    sh_en;

    logic          slot_end;
    logic          frame_end;
    logic [3:0]    cur_nib;
    logic [6:0]    cur_seg;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign cur_nib   = sh_dig[{idx, 2'b00} +: 4];

    hex_to_7seg u_hex_to_7seg (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

    // Slot counter, digit index, state and the registered display outputs.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            cnt        <= '0;
            idx        <= '0;
            state      <= ST_BLANK;
            AN         <= AN_OFF;
            hexdisp    <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;

            if (state == ST_DRIVE && sh_en[idx]) begin
                AN      <= ~(8'd1 << idx);
                hexdisp <= cur_seg;
            end else begin
                AN      <= AN_OFF;
                hexdisp <= SEG_OFF;
            end

            if (slot_end) begin
                cnt   <= '0;
                idx   <= idx + 3'd1;
                state <= ST_BLANK;
            end else begin
                cnt <= cnt + 1'b1;
                if (cnt == BLANK_LAST) begin
                    state <= ST_DRIVE;
                end
            end
        end
    end

    // Shadow only moves at the frame boundary so a frame never mixes old and new digits;
    // a load landing on the boundary cycle bypasses staging and applies at once.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            stg_dig      <= '0;
            stg_en       <= '0;
            sh_dig       <= '0;
            sh_en        <= '0;
            load_pending <= 1'b0;
        end else begin
            if (load) begin
                stg_dig <= digits_in;
                stg_en  <= digit_en;
            end

            if (frame_end) begin
                sh_dig       <= load ? digits_in : stg_dig;
                sh_en        <= load ? digit_en  : stg_en;
                load_pending <= 1'b0;
            end else if (load) begin
                load_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl at REFRESH_DIV=8, BLANK_CYCLES=2 with a per-cycle expectation queue.
module tb_seg_scan_ctrl;

    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 8 * RD;

    logic        CLK100MHZ  = 1'b0;
    logic        CPU_RESETN = 1'b1;
    logic [31:0] digits_in  = '0;
    logic [7:0]  digit_en   = '0;
    logic        load       = 1'b0;
    logic [7:0]  AN;
    logic [6:0]  hexdisp;
    logic        frame_done;
    logic        load_pending;

    seg_scan_ctrl #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .CLK100MHZ    (CLK100MHZ),
        .CPU_RESETN   (CPU_RESETN),
        .digits_in    (digits_in),
        .digit_en     (digit_en),
        .load         (load),
        .AN           (AN),
        .hexdisp      (hexdisp),
        .frame_done   (frame_done),
        .load_pending (load_pending)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] hex;
        logic       fd;
        logic       lp;
    } exp_t;

    exp_t sb[$];

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int          checks = 0;
    int          errors = 0;
    int          n      = 0;
    logic [31:0] sh_dig = '0;
    logic [7:0]  sh_en  = '0;
    logic [31:0] stg_dig = '0;
    logic [7:0]  stg_en  = '0;
    logic        pend    = 1'b0;
    logic        fd_win  = 1'b0;
    int          fd_cnt  = 0;
    int          fd_last = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at position %0d", tag, obs, exp, n);
        end
    endtask

    // One clock: expected outputs follow from the slot position before the edge.
    task automatic step(input logic ld, input logic [31:0] d, input logic [7:0] e);
        exp_t       x;
        int         c;
        int         slot;
        logic       bnd;
        logic [3:0] nib;
        c    = n % RD;
        slot = (n / RD) % 8;
        bnd  = ((n % FRAME) == FRAME - 1);
        load      = ld;
        digits_in = d;
        digit_en  = e;
        if (c < BC || !sh_en[slot]) begin
            x.an  = 8'hFF;
            x.hex = 7'h7F;
        end else begin
            x.an  = ~(8'd1 << slot);
            nib   = sh_dig[slot*4 +: 4];
            x.hex = seg_tab[nib];
        end
        x.fd = bnd;
        x.lp = bnd ? 1'b0 : (ld ? 1'b1 : pend);
        sb.push_back(x);
        if (ld) begin
            stg_dig = d;
            stg_en  = e;
        end
        if (bnd) begin
            sh_dig = stg_dig;
            sh_en  = stg_en;
        end
        pend = x.lp;
        n++;
        @(posedge CLK100MHZ);
        #1;
        load = 1'b0;
        x = sb.pop_front();
        chk("an", {24'd0, AN}, {24'd0, x.an});
        chk("hexdisp", {25'd0, hexdisp}, {25'd0, x.hex});
        chk("frame_done", {31'd0, frame_done}, {31'd0, x.fd});
        chk("load_pending", {31'd0, load_pending}, {31'd0, x.lp});
        chk("an_onehot", {31'd0, ($countones(~AN) <= 1)}, 32'd1);
        if (fd_win && frame_done === 1'b1) begin
            if (fd_last >= 0) chk("fd_spacing", n - fd_last, FRAME);
            fd_last = n;
            fd_cnt++;
        end
    endtask

    // Idle cycles with wandering inputs that must not reach the display.
    task automatic run(input int k);
        for (int i = 0; i < k; i++) step(1'b0, $urandom, 8'($urandom));
    endtask

    task automatic model_reset();
        n       = 0;
        sh_dig  = '0;
        sh_en   = '0;
        stg_dig = '0;
        stg_en  = '0;
        pend    = 1'b0;
    endtask

    initial begin
        #2 CPU_RESETN = 1'b0;
        #1;
        chk("rst_an", {24'd0, AN}, 32'hFF);
        chk("rst_hex", {25'd0, hexdisp}, 32'h7F);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        chk("rst_lp", {31'd0, load_pending}, 32'd0);
        @(posedge CLK100MHZ);
        #1 CPU_RESETN = 1'b1;
        model_reset();

        // All digits enabled; dark frame until the first boundary, then 0..7.
        step(1'b1, 32'h76543210, 8'hFF);
        run(127);

        // Even digits disabled.
        step(1'b1, 32'h76543210, 8'b1010_1010);
        run(127);

        // Two loads inside one frame: the later one wins at the boundary.
        run(10);
        step(1'b1, 32'hFEDCBA98, 8'hFF);
        run(20);
        step(1'b1, 32'h11111111, 8'hFF);
        run(96);

        // Load on the boundary cycle itself.
        run(63);
        step(1'b1, 32'hABCDEF01, 8'hFF);
        run(64);

        // Asynchronous reset in the driven part of slot 5.
        run(45);
        #2 CPU_RESETN = 1'b0;
        #1;
        chk("async_rst_an", {24'd0, AN}, 32'hFF);
        chk("async_rst_hex", {25'd0, hexdisp}, 32'h7F);
        chk("async_rst_fd", {31'd0, frame_done}, 32'd0);
        chk("async_rst_lp", {31'd0, load_pending}, 32'd0);
        @(posedge CLK100MHZ);
        #1 CPU_RESETN = 1'b1;
        model_reset();
        run(128);

        // Free-run four frames counting frame_done pulses.
        step(1'b1, 32'h0F1E2D3C, 8'hFF);
        fd_win = 1'b1;
        run(256);
        fd_win = 1'b0;
        chk("fd_count", fd_cnt, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles per digit slot (1 kHz slot rate at 100 MHz); legal range >= BLANK_CYCLES+1.
REQ-002 Parameter BLANK_CYCLES, default 64, dead-time cycles at the start of each slot with all anodes off; legal range >= 1.
REQ-003 CLK100MHZ  in  1  sole clock, rising-edge.
REQ-004 CPU_RESETN  in  1  reset, asynchronous, active-low.
REQ-005 digits_in  in  32  eight hex nibbles; nibble k = digits_in[4k+3:4k] drives digit k.
REQ-006 digit_en  in  8  per-digit enable; bit k = 0 keeps digit k dark.
REQ-007 load  in  1  single-cycle request to capture digits_in and digit_en into the shadow registers.
REQ-008 AN  out  8  anode select, active-low, at most one bit low at any time.
REQ-009 hexdisp  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 frame_done  out  1  one-cycle pulse at each digit-7 -> digit-0 wrap.
REQ-011 load_pending  out  1  high from accepted load until shadow update.

Function
REQ-012 Slot counter cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; digit index idx (3 bits) SHALL advance on the cnt wrap, with 7 -> 0 wrap.
REQ-013 FSM states: BLANK (cnt < BLANK_CYCLES) and DRIVE (cnt >= BLANK_CYCLES); BLANK -> DRIVE when cnt reaches BLANK_CYCLES; DRIVE -> BLANK on cnt wrap.
REQ-014 In BLANK: AN = 8'hFF, hexdisp = 7'h7F.
REQ-015 In DRIVE with shadow enable bit idx = 1: AN = ~(8'b1 << idx), hexdisp = decode(shadow nibble idx); with enable = 0: AN = 8'hFF, hexdisp = 7'h7F.
REQ-016 AN, hexdisp and frame_done SHALL be registered, each lagging the cnt/idx/state it reflects by exactly one clock.
REQ-017 Decode: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
REQ-018 load=1 SHALL capture digits_in/digit_en into a staging register and set load_pending; a later load before the update SHALL overwrite staging (latest wins).
REQ-019 Shadow registers SHALL update from staging only on the cycle cnt=REFRESH_DIV-1 with idx=7 (frame boundary); load_pending clears on that same cycle.
REQ-020 load coincident with the frame-boundary cycle SHALL capture that cycle's data and apply it at that boundary; load_pending remains low.
REQ-021 frame_done SHALL pulse for exactly one cycle per frame (every 8*REFRESH_DIV cycles), one cycle after the frame-boundary cycle.
REQ-022 Input changes without load SHALL have no effect on outputs.

Reset
REQ-023 CPU_RESETN low SHALL immediately, regardless of clock, force cnt=0, idx=0, state BLANK, AN=8'hFF, hexdisp=7'h7F, frame_done=0, load_pending=0, shadow and staging = 0 (all enables off).
REQ-024 Reset asserted mid-slot or mid-pending-load SHALL discard the pending load; after release the first slot is a full-length digit-0 slot starting in BLANK.

Structure
REQ-025 Package seg_pkg SHALL hold NUM_DIGITS=8, the 16 segment-pattern constants, SEG_OFF=7'h7F, AN_OFF=8'hFF and the state enum.
REQ-026 Sub-module hex_to_7seg (4-bit in, 7-bit active-low out, combinational, per REQ-017) SHALL be instantiated once.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-027 Reset then load digits_in=32'h76543210, digit_en=8'hFF -> after first frame boundary, slot k shows AN=~(1<<k) with hexdisp = pattern k for 6 cycles, preceded by 2 cycles AN=8'hFF.
REQ-028 digit_en=8'b1010_1010 -> slots 0,2,4,6 hold AN=8'hFF and hexdisp=7'h7F for all 8 cycles.
REQ-029 Load 32'hFEDCBA98 mid-frame, then 32'h11111111 before the boundary -> load_pending high until the boundary, old digits finish the frame, next frame shows all 7'h79.
REQ-030 load on the frame-boundary cycle -> new data visible in the following frame's slot 0, load_pending never asserts.
REQ-031 CPU_RESETN pulsed low asynchronously during DRIVE of slot 5 -> AN=8'hFF same instant, restart at digit 0 in BLANK, display dark until next load and boundary.
REQ-032 Free-run 4 frames -> frame_done exactly 4 one-cycle pulses spaced 64 cycles; AN never has more than one bit low.
